// File: rtl/lsys_expander.sv
// Depth-first expander for the L-system F -> F+F-F-F+F (axiom F), streaming one
// turtle symbol per valid/ready handshake using a per-depth position stack.
module lsys_expander #(
    parameter int MAX_ITER = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  iterations,
    input  logic        start,
    output logic [1:0]  sym,
    output logic        sym_valid,
    input  logic        sym_ready,
    output logic        sym_last,
    output logic        busy,
    output logic        done,
    output logic [31:0] f_count
);
    localparam int DW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
    localparam logic [1:0] SYM_F = 2'b00;
    localparam logic [1:0] SYM_L = 2'b01;
    localparam logic [1:0] SYM_R = 2'b10;

    typedef enum logic [1:0] {IDLE, WALK, EMIT, POP} state_t;

    state_t                   state_q, state_d;
    logic [DW-1:0]            n_q, n_d;
    logic [DW-1:0]            d_q, d_d;
    logic [MAX_ITER:0][3:0]   pos_q, pos_d;
    logic [1:0]               sym_q, sym_d;
    logic                     sym_valid_q, sym_valid_d;
    logic                     sym_last_q, sym_last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [31:0]              f_count_q, f_count_d;

    logic [3:0]               cur_pos;
    logic [1:0]               cur_sym;
    logic [DW-1:0]            up;
    logic                     all_last;

    // Depth 0 holds the axiom "F"; every deeper level holds the rule body.
    function automatic logic [1:0] rule_sym(input logic [DW-1:0] d, input logic [3:0] p);
        if (d == '0) return SYM_F;
        case (p)
            4'd1, 4'd7: return SYM_L;
            4'd3, 4'd5: return SYM_R;
            default:    return SYM_F;
        endcase
    endfunction

    function automatic logic [3:0] rule_len(input logic [DW-1:0] d);
        return (d == '0) ? 4'd1 : 4'd9;
    endfunction

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        d_d         = d_q;
        pos_d       = pos_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        sym_last_d  = sym_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        f_count_d   = f_count_q;

        cur_pos = pos_q[d_q];
        cur_sym = rule_sym(d_q, cur_pos);
        up      = d_q - DW'(1);

        // Final symbol overall only when every open level is on its last slot.
        all_last = 1'b1;
        for (int k = 0; k <= MAX_ITER; k++) begin
            if (k <= int'(d_q) && pos_q[k] != rule_len(DW'(k)) - 4'd1)
                all_last = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (int'(iterations) > MAX_ITER) n_d = DW'(MAX_ITER);
                    else                              n_d = DW'(iterations);
                    d_d       = '0;
                    pos_d[0]  = 4'd0;
                    f_count_d = '0;
                    busy_d    = 1'b1;
                    state_d   = WALK;
                end
            end
            WALK: begin
                if (cur_sym == SYM_F && d_q < n_q) begin
                    d_d                   = d_q + DW'(1);
                    pos_d[d_q + DW'(1)]   = 4'd0;
                end else begin
                    sym_d       = cur_sym;
                    sym_valid_d = 1'b1;
                    sym_last_d  = all_last;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (sym_ready) begin
                    sym_valid_d = 1'b0;
                    sym_last_d  = 1'b0;
                    if (sym_q == SYM_F) f_count_d = f_count_q + 32'd1;
                    pos_d[d_q] = cur_pos + 4'd1;
                    if (cur_pos + 4'd1 < rule_len(d_q)) state_d = WALK;
                    else                                state_d = POP;
                end
            end
            POP: begin
                if (d_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    d_d       = up;
                    pos_d[up] = pos_q[up] + 4'd1;
                    if (pos_q[up] + 4'd1 < rule_len(up)) state_d = WALK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            d_q         <= '0;
            pos_q       <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            f_count_q   <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            d_q         <= d_d;
            pos_q       <= pos_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            sym_last_q  <= sym_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            f_count_q   <= f_count_d;
        end
    end

    assign sym       = sym_q;
    assign sym_valid = sym_valid_q;
    assign sym_last  = sym_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign f_count   = f_count_q;
endmodule

// File: doc/lsys_expander.md
# lsys_expander

Streams the symbol sequence of an L-system expanded to a programmed depth. The block consumes the 4-bit iteration count written by the HPS through the iterations PIO and performs a depth-first expansion of the fixed rule F -> F+F-F-F+F from axiom F. It emits one turtle symbol per valid/ready handshake to the downstream turtle/line-drawing stage. Expansion uses a per-depth position stack, never the materialised string.

## Interface
- MAX_ITER, 15, deepest expansion supported; stack depth is MAX_ITER+1 entries.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- iterations  in  4  expansion depth N, driven by the iterations PIO; sampled only on an accepted start.
- start  in  1  single-cycle request to begin an expansion.
- sym  out  2  symbol code: 2'b00 F (draw forward), 2'b01 '+' (turn left), 2'b10 '-' (turn right); 2'b11 is never emitted.
- sym_valid  out  1  sym holds a symbol.
- sym_ready  in  1  downstream accepts the symbol; the handshake completes on clk when sym_valid && sym_ready.
- sym_last  out  1  qualifies the final symbol of the expansion.
- busy  out  1  expansion in progress, from accepted start through the final handshake.
- done  out  1  one-cycle pulse after the final handshake.
- f_count  out  32  count of F symbols handshaked in the current or most recent run.

## Operation
- States: IDLE, WALK, EMIT, POP.
- Rule at depth 0 is "F" (length 1). Rule at depths 1..N is "F+F-F-F+F" (length 9). Each depth d keeps pos[d], 4 bits.
- IDLE:
  - start accepts: latch N = min(iterations, MAX_ITER), set d=0 and pos[0]=0, clear f_count, set busy, go to WALK.
  - start is ignored in every other state.
- WALK: read the symbol s at rule(d)[pos[d]].
  - If s==F and d<N: set d=d+1 and pos[d+1]=0; stay in WALK. This cycle produces no output.
  - Otherwise: register s onto sym, raise sym_valid, go to EMIT.
- EMIT: hold sym, sym_valid and sym_last stable until the handshake. On the handshake:
  - drop sym_valid;
  - f_count += 1 if the symbol was F;
  - pos[d] += 1.
  - If pos[d] < len(d), go to WALK. Otherwise go to POP.
- POP: pos[d] has reached len(d).
  - If d==0: the expansion is finished. Clear busy, pulse done, go to IDLE.
  - Else: set d=d-1 and pos[d-1] += 1. If pos[d-1] is still < len(d-1), go to WALK; otherwise stay in POP. Pops cascade one level per cycle.
- sym_last is computed at the WALK->EMIT decision. It is asserted iff every level 0..d sits at its last position (pos[k]==len(k)-1).
- Expected results: total symbols S(N) = 5*S(N-1)+4 with S(0)=1, i.e. 1, 9, 49, 249, ... F count is 5^N.
- f_count wraps modulo 2^32; N≥14 wraps. There is no saturation and no error flag.
- Changes on iterations while busy have no effect.

## Timing
- Reset: state IDLE, sym=0, sym_valid=0, sym_last=0, busy=0, done=0, f_count=0, d=0. All pos entries are cleared.
- Reset mid-run takes effect at the next edge. The partially sent stream is abandoned and there is no sym_last.
- Start accepted at edge t:
  - busy=1 from t+1;
  - first sym_valid at t+N+2 (N descend cycles plus one WALK decision cycle).
- Between handshakes sym_valid is low for at least 1 cycle (EMIT->WALK). The gap is bounded by 2*N+2 cycles.
- sym_valid never deasserts without a handshake. sym may change only in the cycle after a handshake.
- Final handshake at edge h: POP at h+1; busy=0 and done=1 during h+1..h+2 (one cycle). The last pop is at d=0 after the cascade, so the gap grows by the cascade depth. A new start is accepted once state is IDLE.
- sym_ready held low indefinitely stalls the block with no loss of state.

## Test plan
- Reset: assert reset for 2 cycles with start=1. Required: all outputs 0, busy stays 0, no sym_valid.
- N=0, sym_ready=1: start at t. Required: sym_valid at t+2 with sym=00 and sym_last=1; done pulses once; f_count=1; busy=0 afterwards.
- N=1, sym_ready=1: required sequence 00,01,00,10,00,10,00,01,00 with sym_last only on the 9th symbol; f_count=5.
- N=2, sym_ready random at 30%: required 49 symbols, 25 F. The first 9 match the N=1 sequence and the 10th is 01. sym must be stable across every stall; exactly one sym_last.
- N=3: pulse start mid-stream, then assert reset after the 20th handshake. Required: the extra start has no effect; the cycle after reset shows busy=0 and sym_valid=0. A subsequent N=1 run produces the exact 9-symbol sequence.
- MAX_ITER=3, iterations=15, sym_ready=1: required clamp to N=3, i.e. 249 symbols, f_count=125, one done pulse.
